// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared FSM state type and width limit for the
// iterative restoring divider (div_iter).
package div_iter_pkg;

    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/div_iter_step.sv
// div_iter_step: one combinational restoring-division step.
// Shifts a dividend bit into the partial remainder and trial-subtracts.
module div_iter_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_sh;
    logic [WIDTH:0] w_diff;

    // Partial remainder is always < divisor, so the shifted value fits
    // in WIDTH+1 bits and a successful subtraction fits back in WIDTH.
    always_comb begin
        w_sh   = {i_rem, i_bit};
        w_diff = w_sh - {1'b0, i_div};
        o_qbit = ~w_diff[WIDTH];
        o_rem  = o_qbit ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
    end

endmodule

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider, one quotient bit/cycle.
// Optional signed mode enabled by macro DIV_ITER_SIGNED_EN (adds port sgn).
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DIV_ITER_SIGNED_EN
    input  logic             sgn,
`endif
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] mod,
    output logic             cal,
    output logic             done,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("div_iter: WIDTH out of range");
    end

    state_t           r_state;
    state_t           w_next;
    logic             w_cal;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_mod;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH-1:0] w_rem_nx;
    logic             w_qbit;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;
    logic [WIDTH-1:0] w_res_fin;
    logic [WIDTH-1:0] w_mod_fin;
    logic             w_last;

    div_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_quo[WIDTH-1]),
        .i_div  (r_div),
        .o_rem  (w_rem_nx),
        .o_qbit (w_qbit)
    );

    // r_quo starts as the dividend and fills with quotient bits from the
    // right as dividend bits leave on the left.
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_qbit};
    assign w_last   = (r_cnt == LAST);

`ifdef DIV_ITER_SIGNED_EN
    logic w_sa;
    logic w_sb;
    logic r_qneg;
    logic r_rneg;

    assign w_sa      = sgn & a[WIDTH-1];
    assign w_sb      = sgn & b[WIDTH-1];
    assign w_amag    = w_sa ? -a : a;
    assign w_bmag    = w_sb ? -b : b;
    assign w_res_fin = r_qneg ? -w_quo_nx : w_quo_nx;
    assign w_mod_fin = r_rneg ? -w_rem_nx : w_rem_nx;

    // Result signs: quotient negative on sign mismatch, remainder
    // follows the dividend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_qneg <= w_sa ^ w_sb;
            r_rneg <= w_sa;
        end
    end
`else
    assign w_amag    = a;
    assign w_bmag    = b;
    assign w_res_fin = w_quo_nx;
    assign w_mod_fin = w_rem_nx;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and the iteration flag.
    always_comb begin
        w_next = r_state;
        w_cal  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (b == '0) ? FIN : CALC;
                end
            end
            CALC: begin
                w_cal = 1'b1;
                if (w_last) begin
                    w_next = FIN;
                end
            end
            FIN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_res  <= '0;
            r_mod  <= '0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= (r_state == FIN);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            r_res <= '1;
                            r_mod <= a;
                            r_dbz <= 1'b1;
                        end else begin
                            r_quo <= w_amag;
                            r_div <= w_bmag;
                            r_rem <= '0;
                            r_cnt <= '0;
                        end
                    end
                end
                CALC: begin
                    r_quo <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_res <= w_res_fin;
                        r_mod <= w_mod_fin;
                        r_dbz <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res  = r_res;
    assign mod  = r_mod;
    assign cal  = w_cal;
    assign done = r_done;
    assign dbz  = r_dbz;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed vectors for div_iter (WIDTH=8) with a
// scoreboard queue checked by an independent done monitor.
module tb_div_iter;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] res;
    logic [W-1:0] mod;
    logic         cal;
    logic         done;
    logic         dbz;

    div_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef DIV_ITER_SIGNED_EN
        .sgn   (sgn),
`endif
        .res   (res),
        .mod   (mod),
        .cal   (cal),
        .done  (done),
        .dbz   (dbz)
    );

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] m;
        logic         z;
        int unsigned  t;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          n_done = 0;
    int          n_cal = 0;
    exp_t        last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done and checks value + timing.
    always @(negedge clk) begin
        if (!rst) begin
            if (cal) n_cal++;
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    last = e;
                    chk("res", res, e.r);
                    chk("mod", mod, e.m);
                    chk("dbz", dbz, e.z);
                    chk("latency", cyc, e.t);
                end
            end
        end
    end

    // Called just after a negedge: drives start for one edge and
    // scrambles the operands afterwards.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sv, input logic [W-1:0] er,
                         input logic [W-1:0] em, input logic ez);
        exp_t e;
        a     = av;
        b     = bv;
        sgn   = sv;
        start = 1'b1;
        e.r   = er;
        e.m   = em;
        e.z   = ez;
        e.t   = cyc + 1 + ((bv == '0) ? 1 : W + 1);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = 8'h5A;
        b     = 8'hC3;
        sgn   = ~sv;
    endtask

    task automatic wait_for(input int tgt);
        for (int k = 0; k < 100 && n_done < tgt; k++) @(negedge clk);
        checks++;
        if (n_done < tgt) begin
            failures++;
            $display("FAIL done_timeout: got %0d dones expected %0d",
                     n_done, tgt);
        end
    endtask

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic sv, input logic [W-1:0] er,
                      input logic [W-1:0] em, input logic ez);
        int base;
        base = n_done;
        issue(av, bv, sv, er, em, ez);
        wait_for(base + 1);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int c0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sgn   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_res", res, 0);
        chk("rst_mod", mod, 0);
        chk("rst_cal", cal, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", dbz, 0);
        rst = 1'b0;

        // First start straight after reset release; also counts cal cycles.
        c0 = n_cal;
        op(8'd109, 8'd5, 1'b0, 8'd21, 8'd4, 1'b0);
        chk("cal_cycles_109_5", n_cal - c0, 8);

        // Results hold after done.
        repeat (3) @(negedge clk);
        chk("hold_res", res, 8'd21);
        chk("hold_mod", mod, 8'd4);
        chk("hold_dbz", dbz, 1'b0);

        c0 = n_cal;
        op(8'd37, 8'd0, 1'b0, 8'd255, 8'd37, 1'b1);
        chk("cal_cycles_dbz", n_cal - c0, 0);

        // Re-pulsed start in CALC (cycle 3) and FIN (cycle 9) is ignored;
        // back-to-back start in the IDLE cycle after FIN is accepted.
        base = n_done;
        issue(8'd200, 8'd10, 1'b0, 8'd20, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("b2b_done_in_idle", done, 1'b1);
        issue(8'd255, 8'd16, 1'b0, 8'd15, 8'd15, 1'b0);
        wait_for(base + 2);
        @(negedge clk);

        // Reset in the 4th CALC cycle aborts with no done.
        base = n_done;
        issue(8'd255, 8'd3, 1'b0, 8'd85, 8'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_cal_before", cal, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("abort_res", res, 0);
        chk("abort_mod", mod, 0);
        chk("abort_cal", cal, 0);
        chk("abort_done", done, 0);
        chk("abort_dbz", dbz, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", n_done, base);
        op(8'd7, 8'd7, 1'b0, 8'd1, 8'd0, 1'b0);

        // Boundary operands.
        op(8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0);
        op(8'd0, 8'd7, 1'b0, 8'd0, 8'd0, 1'b0);
        op(8'd5, 8'd9, 1'b0, 8'd0, 8'd5, 1'b0);
        op(8'd255, 8'd255, 1'b0, 8'd1, 8'd0, 1'b0);
        op(8'd128, 8'd2, 1'b0, 8'd64, 8'd0, 1'b0);
        op(8'd0, 8'd0, 1'b0, 8'd255, 8'd0, 1'b1);
        op(8'd250, 8'd13, 1'b0, 8'd19, 8'd3, 1'b0);

`ifdef DIV_ITER_SIGNED_EN
        op(8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0);
        op(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
        op(8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0);
        op(8'hF9, 8'hFE, 1'b1, 8'h03, 8'hFF, 1'b0);
        op(8'hF9, 8'h00, 1'b1, 8'hFF, 8'hF9, 1'b1);
        op(8'hF9, 8'h02, 1'b0, 8'h7C, 8'h01, 1'b0);
`endif

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
